tdm_slot_arbiter: RTL and testbench

- Shares one DATA_W-bit storage register among N_REQ requesters using fixed time-division slots.
- Each slot is owned by exactly one requester; only the owner may write the register.
- A guard/flush window between slots clears the register, so no requester ever observes another requester's data.
- Sits in front of the shared-register datapath as its sequencer and access controller.

---
 rtl/tdm_pkg.sv | 19 +
 rtl/tdm_slot_timer.sv | 57 +++++
 rtl/tdm_slot_arbiter.sv | 123 ++++++++++++
 tb/tb_tdm_slot_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared types and helpers for the TDM slot arbiter: slot phase enum,
// owner-index width computation and a one-hot encoder.
package tdm_pkg;

    typedef enum logic {
        FLUSH  = 1'b0,
        ACTIVE = 1'b1
    } tdm_state_e;

    function automatic int calcOwnW(input int nReq);
        return (nReq < 2) ? 1 : $clog2(nReq);
    endfunction

    // Callers slice the low N_REQ bits of the result.
    function automatic logic [31:0] onehot(input logic [31:0] idx);
        return 32'd1 << idx;
    endfunction

endpackage

// File: rtl/tdm_slot_timer.sv
// Slot phase sequencer: alternates GUARD_LEN flush cycles with SLOT_LEN
// active cycles; skip_i holds the sequencer in FLUSH for another guard window.
module tdm_slot_timer
    import tdm_pkg::*;
#(
    parameter int SLOT_LEN  = 8,
    parameter int GUARD_LEN = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic skip_i,
    output logic slotEnd_o,
    output logic flushEnd_o,
    output logic active_o
);

    localparam int MAX_LEN = (SLOT_LEN > GUARD_LEN) ? SLOT_LEN : GUARD_LEN;
    localparam int CNT_W   = (MAX_LEN < 2) ? 1 : $clog2(MAX_LEN);

    tdm_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FLUSH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter always restarts at zero on a phase change, so it never exceeds MAX_LEN-1.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        slotEnd_o  = 1'b0;
        flushEnd_o = 1'b0;
        active_o   = (state_q == ACTIVE);
        if (state_q == ACTIVE) begin
            if (cnt_q == CNT_W'(SLOT_LEN - 1)) begin
                slotEnd_o = 1'b1;
                state_d   = FLUSH;
                cnt_d     = '0;
            end
        end else begin
            if (cnt_q == CNT_W'(GUARD_LEN - 1)) begin
                flushEnd_o = 1'b1;
                cnt_d      = '0;
                if (!skip_i) begin
                    state_d = ACTIVE;
                end
            end
        end
    end

endmodule

// File: rtl/tdm_slot_arbiter.sv
// Time-division arbiter guarding one shared register among N_REQ requesters.
// Define TDM_SLOT_SKIP_EN to let idle slots be skipped at the end of FLUSH.
module tdm_slot_arbiter
    import tdm_pkg::*;
#(
    parameter  int N_REQ     = 4,
    parameter  int DATA_W    = 8,
    parameter  int SLOT_LEN  = 8,
    parameter  int GUARD_LEN = 1,
    localparam int OWN_W     = calcOwnW(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   data_in,
    output logic [N_REQ-1:0]          grant,
    output logic [OWN_W-1:0]          slot_owner,
    output logic                      flush,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_valid,
    output logic [OWN_W-1:0]          out_owner
);

    logic               slotEnd, flushEnd, active, skip;
    logic               ownerReq;
    logic [31:0]        onehotVec;
    logic [DATA_W-1:0]  ownerData;
    logic [OWN_W-1:0]   nextOwner;

    logic [OWN_W-1:0]   slotOwner_q, slotOwner_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               valid_q, valid_d;
    logic [OWN_W-1:0]   outOwner_q, outOwner_d;

    tdm_slot_timer #(
        .SLOT_LEN  (SLOT_LEN),
        .GUARD_LEN (GUARD_LEN)
    ) u_timer (
        .clk_i      (clk),
        .rst_i      (rst),
        .skip_i     (skip),
        .slotEnd_o  (slotEnd),
        .flushEnd_o (flushEnd),
        .active_o   (active)
    );

    assign ownerReq  = req[slotOwner_q];
    assign ownerData = data_in[slotOwner_q*DATA_W +: DATA_W];
    assign nextOwner = (slotOwner_q == OWN_W'(N_REQ - 1)) ? '0 : slotOwner_q + 1'b1;

`ifdef TDM_SLOT_SKIP_EN
    logic [OWN_W-1:0] skipCnt_q, skipCnt_d;

    // Bounded so that after N_REQ-1 skips the last candidate always gets its slot.
    always_comb begin
        skip      = flushEnd && !ownerReq && (skipCnt_q != OWN_W'(N_REQ - 1));
        skipCnt_d = skipCnt_q;
        if (skip) begin
            skipCnt_d = skipCnt_q + 1'b1;
        end else if (flushEnd) begin
            skipCnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skipCnt_q <= '0;
        end else begin
            skipCnt_q <= skipCnt_d;
        end
    end
`else
    assign skip = 1'b0;
`endif

    always_comb begin
        onehotVec = onehot(32'(slotOwner_q));
        grant     = '0;
        if (active) begin
            grant = onehotVec[N_REQ-1:0] & req;
        end
    end

    // FLUSH wipes the register every cycle so no data crosses a slot boundary.
    always_comb begin
        slotOwner_d = slotOwner_q;
        data_d      = data_q;
        valid_d     = valid_q;
        outOwner_d  = outOwner_q;
        if (slotEnd || skip) begin
            slotOwner_d = nextOwner;
        end
        if (!active) begin
            data_d  = '0;
            valid_d = 1'b0;
        end else if (ownerReq) begin
            data_d     = ownerData;
            valid_d    = 1'b1;
            outOwner_d = slotOwner_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slotOwner_q <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            outOwner_q  <= '0;
        end else begin
            slotOwner_q <= slotOwner_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            outOwner_q  <= outOwner_d;
        end
    end

    assign slot_owner = slotOwner_q;
    assign flush      = !active;
    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign out_owner  = outOwner_q;

endmodule

// File: tb/tb_tdm_slot_arbiter.sv
// Self-checking bench for tdm_slot_arbiter (fixed-schedule build): the schedule
// model derives owner and phase from the cycle count since reset.
module tb_tdm_slot_arbiter;

    localparam int N_REQ       = 4;
    localparam int DATA_W      = 8;
    localparam int SLOT_LEN    = 8;
    localparam int GUARD_LEN   = 1;
    localparam int OWN_W       = 2;
    localparam int SLOT_PERIOD = SLOT_LEN + GUARD_LEN;
    localparam int FRAME       = SLOT_PERIOD * N_REQ;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [N_REQ-1:0]         req;
    logic [N_REQ*DATA_W-1:0]  data_in;
    logic [N_REQ-1:0]         grant;
    logic [OWN_W-1:0]         slot_owner;
    logic                     flush;
    logic [DATA_W-1:0]        out_data;
    logic                     out_valid;
    logic [OWN_W-1:0]         out_owner;

    int total = 0;
    int bad   = 0;

    int                t;
    bit                modelValid = 1'b0;
    logic [DATA_W-1:0] mData;
    bit                mValid;
    int                mOwner;

    tdm_slot_arbiter #(
        .N_REQ     (N_REQ),
        .DATA_W    (DATA_W),
        .SLOT_LEN  (SLOT_LEN),
        .GUARD_LEN (GUARD_LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .data_in    (data_in),
        .grant      (grant),
        .slot_owner (slot_owner),
        .flush      (flush),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_owner  (out_owner)
    );

    always #5 clk = ~clk;

    function automatic int modelOwner(input int tt);
        return (tt % FRAME) / SLOT_PERIOD;
    endfunction

    function automatic bit modelFlush(input int tt);
        return ((tt % FRAME) % SLOT_PERIOD) < GUARD_LEN;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0d)", name, actual, expected, t);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [N_REQ-1:0] rq, input logic [N_REQ*DATA_W-1:0] d);
        rst     = r;
        req     = rq;
        data_in = d;
    endtask

    task automatic stepCycle();
        logic [N_REQ-1:0] eGrant;
        int k;
        k = 0;
        #4;
        if (modelValid) begin
            k      = modelOwner(t);
            eGrant = '0;
            if (!modelFlush(t)) eGrant[k] = req[k];
            checkOutput("grant", 32'(grant), 32'(eGrant));
            checkOutput("slot_owner", 32'(slot_owner), 32'(k));
            checkOutput("flush", 32'(flush), 32'(modelFlush(t)));
            checkOutput("out_data", 32'(out_data), 32'(mData));
            checkOutput("out_valid", 32'(out_valid), 32'(mValid));
            checkOutput("out_owner", 32'(out_owner), 32'(mOwner));
        end
        @(posedge clk);
        if (rst) begin
            t          = 0;
            mData      = '0;
            mValid     = 1'b0;
            mOwner     = 0;
            modelValid = 1'b1;
        end else if (modelValid) begin
            if (modelFlush(t)) begin
                mData  = '0;
                mValid = 1'b0;
            end else if (req[k]) begin
                mData  = data_in[k*DATA_W +: DATA_W];
                mValid = 1'b1;
                mOwner = k;
            end
            t++;
        end
        #1;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            applyStimulus(1'b0, '0, '0);
            stepCycle();
        end
    endtask

    initial begin
        t = 0;
        applyStimulus(1'b1, '0, '0);
        @(posedge clk);
        #1;
        stepCycle();
        stepCycle();

        checkOutput("lit_reset_owner", 32'(slot_owner), 32'd0);
        checkOutput("lit_reset_flush", 32'(flush), 32'd1);
        checkOutput("lit_reset_data", 32'(out_data), 32'd0);
        checkOutput("lit_reset_valid", 32'(out_valid), 32'd0);

        idleCycles(10);
        checkOutput("lit_slot1_owner", 32'(slot_owner), 32'd1);
        checkOutput("lit_slot1_flush", 32'(flush), 32'd0);
        applyStimulus(1'b0, 4'b0010, 32'h0000_A500);
        #2;
        checkOutput("lit_owner_grant", 32'(grant), 32'h2);
        stepCycle();
        checkOutput("lit_write_data", 32'(out_data), 32'hA5);
        checkOutput("lit_write_valid", 32'(out_valid), 32'd1);
        checkOutput("lit_write_owner", 32'(out_owner), 32'd1);

        idleCycles(8);
        checkOutput("lit_leak_owner", 32'(slot_owner), 32'd2);
        checkOutput("lit_leak_data", 32'(out_data), 32'd0);
        checkOutput("lit_leak_valid", 32'(out_valid), 32'd0);

        idleCycles(18);
        checkOutput("lit_slot0_owner", 32'(slot_owner), 32'd0);
        applyStimulus(1'b0, 4'b1110, 32'hFFFF_FFFF);
        #2;
        checkOutput("lit_nonowner_grant", 32'(grant), 32'd0);
        stepCycle();
        checkOutput("lit_nonowner_valid", 32'(out_valid), 32'd0);
        checkOutput("lit_nonowner_data", 32'(out_data), 32'd0);

        idleCycles(33);
        applyStimulus(1'b0, 4'b1000, 32'h3C00_0000);
        stepCycle();
        checkOutput("lit_boundary_data", 32'(out_data), 32'h3C);
        checkOutput("lit_boundary_wrap", 32'(slot_owner), 32'd0);
        checkOutput("lit_boundary_flush", 32'(flush), 32'd1);
        idleCycles(1);
        checkOutput("lit_boundary_clear", 32'(out_data), 32'd0);

        idleCycles(21);
        checkOutput("lit_midslot_owner", 32'(slot_owner), 32'd2);
        applyStimulus(1'b1, 4'b0100, 32'h0077_0000);
        stepCycle();
        checkOutput("lit_rst_flush", 32'(flush), 32'd1);
        checkOutput("lit_rst_owner", 32'(slot_owner), 32'd0);
        checkOutput("lit_rst_data", 32'(out_data), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 299) == 0, N_REQ'($urandom), $urandom);
            stepCycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
